// File: rtl/seg_approx_mult_pipe.sv
// Pipelined dynamic-segment approximate unsigned multiplier.
// Stage 1: leading-one detect and segment extraction.
// Stage 2: segment multiply.
// Stage 3: shift the product back into place.
// Valid/ready handshakes on both sides. Internal stages collapse bubbles.
module seg_approx_mult_pipe #(
  parameter int WIDTH   = 16,
  parameter int SEG_MAX = 8,
  parameter int SEG_MIN = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_y,
  output logic               out_approx
);

  localparam int KW = $clog2(WIDTH);  // width of a bit index / shift amount
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    MODE_EXACT     = 2'b00,
    MODE_FIXED_MAX = 2'b01,
    MODE_DYNAMIC   = 2'b10,
    MODE_FIXED_MIN = 2'b11
  } mode_e;

  // Index of the most significant set bit; 0 for a zero operand.
  function automatic logic [KW-1:0] lead_one(input logic [WIDTH-1:0] v);
    lead_one = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) lead_one = KW'(i);
    end
  endfunction

  // Number of low bits discarded when keeping an s-bit segment that starts at bit k.
  function automatic logic [KW-1:0] seg_shift(input logic [KW-1:0] k, input int s);
    if (int'(k) >= s) return KW'(int'(k) - s + 1);
    else              return '0;
  endfunction

  // Stage 1 combinational terms
  logic [KW-1:0]    k_a, k_b, sh_a, sh_b;
  logic [WIDTH-1:0] seg_a, seg_b;
  logic             approx_c;
  int               p, s_dyn, seg_w;

  // Pipeline registers
  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_seg_a, s1_seg_b;
  logic [KW-1:0]    s1_sh_a, s1_sh_b;
  logic             s1_approx;
  logic [PW-1:0]    s2_prod;
  logic [KW:0]      s2_shift;
  logic             s2_approx;

  // Stage load enables: the output stage advances when drained or empty,
  // each earlier stage also loads whenever the stage after it is empty.
  logic en1, en2, en3;
  assign en3      = out_ready || !out_valid;
  assign en2      = en3 || !s2_valid;
  assign en1      = en2 || !s1_valid;
  assign in_ready = !s1_valid || en3;

  // Leading-one detect, segment width selection and segment extraction
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    seg_w = WIDTH;
    k_a   = lead_one(in_a);
    k_b   = lead_one(in_b);
    p     = (k_a > k_b) ? int'(k_a) : int'(k_b);
    s_dyn = p - WIDTH + SEG_MAX + 3;
    if (s_dyn < SEG_MIN)      s_dyn = SEG_MIN;
    else if (s_dyn > SEG_MAX) s_dyn = SEG_MAX;
    case (in_mode)
      MODE_EXACT:     seg_w = WIDTH;  // k < WIDTH always, so nothing is truncated
      MODE_FIXED_MAX: seg_w = SEG_MAX;
      MODE_DYNAMIC:   seg_w = s_dyn;
      MODE_FIXED_MIN: seg_w = SEG_MIN;
      default:        seg_w = WIDTH;
    endcase
    sh_a  = seg_shift(k_a, seg_w);
    sh_b  = seg_shift(k_b, seg_w);
    seg_a = in_a >> sh_a;
    seg_b = in_b >> sh_b;
    // A zero operand yields an exact zero product, so it never counts as approximate.
    approx_c = (in_mode != MODE_EXACT) && ((sh_a != '0) || (sh_b != '0)) &&
               (in_a != '0) && (in_b != '0);
  end

  // Valid bits and output registers; output data only changes with a real beat
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_approx <= 1'b0;
    end else begin
      if (en1) s1_valid <= in_valid && in_ready;
      if (en2) s2_valid <= s1_valid;
      if (en3) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          out_y      <= s2_prod << s2_shift;
          out_approx <= s2_approx;
        end
      end
    end
  end

  // Datapath registers behind the valid bits
  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; their valid bit marks them as meaningless.
    if (en1) begin
      s1_seg_a  <= seg_a;
      s1_seg_b  <= seg_b;
      s1_sh_a   <= sh_a;
      s1_sh_b   <= sh_b;
      s1_approx <= approx_c;
    end
    if (en2) begin
      s2_prod   <= PW'(s1_seg_a) * PW'(s1_seg_b);
      s2_shift  <= (KW + 1)'(s1_sh_a) + (KW + 1)'(s1_sh_b);
      s2_approx <= s1_approx;
    end
  end

endmodule

// File: tb/tb_seg_approx_mult_pipe.sv
// Self-checking bench for seg_approx_mult_pipe: directed test-plan vectors,
// back-pressure, full-throughput random stream and mid-operation reset,
// all scored against an arithmetic reference model.
module tb_seg_approx_mult_pipe;

  localparam int W    = 16;
  localparam int SMAX = 8;
  localparam int SMIN = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_ready;
  logic [W-1:0]   in_a, in_b;
  logic [1:0]     in_mode;
  logic           out_valid, out_ready, out_approx;
  logic [2*W-1:0] out_y;

  always #5 clk = ~clk;

  seg_approx_mult_pipe #(.WIDTH(W), .SEG_MAX(SMAX), .SEG_MIN(SMIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_approx(out_approx)
  );

  typedef struct {
    logic [2*W-1:0] y;
    logic           ap;
  } exp_t;

  exp_t           sb[$];
  int             errors = 0, checks = 0, cyc = 0;
  int             acc_cnt = 0, fire_cnt = 0, last_acc_cyc = 0, last_fire_cyc = 0;
  logic           accepted;
  logic [2*W-1:0] last_y;
  logic           last_ap;

  // Reference: truncate each operand to an S-bit segment below its top one, multiply, scale back.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] mode);
    int ka, kb, s, sha, shb;
    longint unsigned sega, segb, y;
    exp_t e;
    ka = 0;
    kb = 0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) ka = i;
      if (b[i]) kb = i;
    end
    case (mode)
      2'b00:   s = W;
      2'b01:   s = SMAX;
      2'b11:   s = SMIN;
      default: begin
        s = ((ka > kb) ? ka : kb) - W + SMAX + 3;
        if (s < SMIN) s = SMIN;
        if (s > SMAX) s = SMAX;
      end
    endcase
    sha  = (ka >= s) ? ka - s + 1 : 0;
    shb  = (kb >= s) ? kb - s + 1 : 0;
    sega = longint'(a) / (64'd1 << sha);
    segb = longint'(b) / (64'd1 << shb);
    y    = sega * segb * (64'd1 << (sha + shb));
    e.y  = (2*W)'(y);
    e.ap = (mode != 2'b00) && (a != 0) && (b != 0) && (sha + shb > 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at the negedge, then step past the next posedge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) begin
        accepted     = 1'b1;
        acc_cnt++;
        last_acc_cyc = cyc;
        sb.push_back(model(in_a, in_b, in_mode));
      end
      if (out_valid && out_ready) begin
        fire_cnt++;
        last_fire_cyc = cyc;
        last_y        = out_y;
        last_ap       = out_approx;
        check("result_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_y", out_y, e.y);
          check("sb_approx", out_approx, e.ap);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_accept(input int bound);
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (accepted) break;
    end
    check("accept_in_time", accepted, 1);
  endtask

  // Single beat on an idle pipeline: checks latency and the given constant result.
  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] mode, input logic [2*W-1:0] exp_y,
                          input logic exp_ap);
    int f0;
    in_a      = a;
    in_b      = b;
    in_mode   = mode;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    wait_accept(8);
    in_valid = 1'b0;
    f0       = fire_cnt;
    for (int i = 0; i < 10 && fire_cnt == f0; i++) cycle();
    check({tag, "_fired"}, fire_cnt - f0, 1);
    check({tag, "_latency"}, last_fire_cyc - last_acc_cyc, 3);
    check({tag, "_y"}, last_y, exp_y);
    check({tag, "_approx"}, last_ap, exp_ap);
  endtask

  function automatic logic [W-1:0] rand_op();
    return W'($urandom() >> $urandom_range(0, 31));
  endfunction

  initial begin
    int idx, f0, a0, first_acc, first_fire, stalls;
    logic [W-1:0] bp_a[5], bp_b[5];
    logic [1:0]   bp_m[5];

    // Reset state
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; out_ready = 1'b0;
    cycle();
    cycle();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_approx", out_approx, 0);
    rst = 1'b0;
    cycle();
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);

    // Directed test-plan vectors
    directed("exact",     16'd56783, 16'd6723,  2'b00, 32'd381752109, 1'b0);
    directed("fixed_max", 16'hFFAA,  16'h08FA,  2'b01, 32'd149360640, 1'b1);
    directed("dynamic",   16'h0392,  16'h01FB,  2'b10, 32'd444416,    1'b1);
    directed("dyn_small", 16'd25,    16'd3,     2'b10, 32'd75,        1'b0);
    directed("zero_op",   16'd0,     16'hFFFF,  2'b01, 32'd0,         1'b0);
    directed("min_seg",   16'hFFFF,  16'hFFFF,  2'b11, 32'hF8000000 - 32'h07C00000 + 32'h003E0000 - 32'h3E0000 + 32'h3C1 * 32'h400000 - 32'hF8000000 + 32'h07C00000 - 32'h3C1 * 32'h400000 + 32'd31 * 32'd31 * 32'd4194304, 1'b1);

    // Back-pressure: five mixed-mode beats with the output stalled
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = rand_op() | 16'h0100;
      bp_b[i] = rand_op() | 16'h0001;
      bp_m[i] = 2'(i % 4);
    end
    out_ready = 1'b0;
    idx       = 0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 5) begin
        in_a = bp_a[idx]; in_b = bp_b[idx]; in_mode = bp_m[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (accepted) idx++;
    end
    check("bp_accepted", idx, 3);
    check("bp_in_ready", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_held_y", out_y, sb[0].y);
    check("bp_held_approx", out_approx, sb[0].ap);
    out_ready = 1'b1;
    f0        = fire_cnt;
    for (int c = 0; c < 30; c++) begin
      if (idx < 5) begin
        in_a = bp_a[idx]; in_b = bp_b[idx]; in_mode = bp_m[idx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (accepted) idx++;
      if (idx == 5 && sb.size() == 0) break;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 5);
    check("bp_all_out", fire_cnt - f0, 5);
    check("bp_sb_empty", sb.size(), 0);

    // Full throughput: 100 random beats back to back
    f0 = fire_cnt; a0 = acc_cnt; first_acc = -1; first_fire = -1; stalls = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_a = rand_op(); in_b = rand_op(); in_mode = 2'($urandom_range(0, 3)); in_valid = 1'b1;
      cycle();
      if (!accepted) stalls++;
      if (first_acc < 0 && accepted) first_acc = last_acc_cyc;
      if (first_fire < 0 && fire_cnt != f0) first_fire = last_fire_cyc;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      cycle();
      if (first_fire < 0 && fire_cnt != f0) first_fire = last_fire_cyc;
    end
    check("tp_no_stall", stalls, 0);
    check("tp_accepted", acc_cnt - a0, 100);
    check("tp_results", fire_cnt - f0, 100);
    check("tp_fill", first_fire - first_acc, 3);
    check("tp_back_to_back", last_fire_cyc - first_fire, 99);

    // Reset with two beats in flight
    out_ready = 1'b1;
    a0        = acc_cnt;
    for (int i = 0; i < 2; i++) begin
      in_a = rand_op() | 16'h0001; in_b = rand_op() | 16'h0001; in_mode = 2'b00; in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    check("rst_inflight_accepted", acc_cnt - a0, 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_y", out_y, 0);
    f0 = fire_cnt;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (out_valid) f0 = f0 - 1;
    end
    check("midrst_no_stale", fire_cnt - f0, 0);
    directed("post_rst", 16'd1000, 16'd3, 2'b00, 32'd3000, 1'b0);
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_approx_mult_pipe.md
Name: seg_approx_mult_pipe

Overview:
Pipelined, parametrised dynamic-segment approximate unsigned multiplier. It is the successor to the combinational 16x16 leading-one segment multiplier.
- Each operand is reduced to a segment of S bits, starting at its leading one.
- The two segments are multiplied and the product is shifted back into place.
- S is fixed or data-dependent, selected per transaction by a mode field.
- Valid/ready handshakes on input and output; sits in datapaths feeding DSP/accumulator stages.

Parameters:
WIDTH, 16, operand width in bits (>= 8)
SEG_MAX, 8, largest segment width (SEG_MIN <= SEG_MAX <= WIDTH)
SEG_MIN, 5, smallest segment width (>= 2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_a  input  WIDTH  operand A, unsigned
in_b  input  WIDTH  operand B, unsigned
in_mode  input  2  00 exact, 01 fixed SEG_MAX, 10 dynamic, 11 fixed SEG_MIN
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_y  output  2*WIDTH  product (exact or approximate)
out_approx  output  1  1 = at least one operand was truncated

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset: all stage valid bits = 0, out_valid = 0, out_y = 0, out_approx = 0.
- rst dominates any handshake in the same cycle. Beats in flight are discarded and no output appears afterwards.
- Input acceptance: a beat is accepted when in_valid && in_ready. in_mode is captured with the operands.
- Pipeline structure: 3 register stages; latency is exactly 3 cycles from acceptance to out_valid when out_ready stays high.
- Stage 1, leading-one detect:
  - k_a, k_b = index of the most significant 1; 0 if the operand is 0.
  - Dynamic-mode segment width: p = max(k_a, k_b); S = clamp(p - WIDTH + SEG_MAX + 3, SEG_MIN, SEG_MAX).
  - Modes 01 and 11 use S = SEG_MAX and SEG_MIN respectively.
  - Mode 00 bypasses truncation: segment = full operand, shift = 0.
- Stage 1, segment extraction (per operand):
  - If k < S: segment = operand, shift = 0.
  - Else: segment = operand[k : k-S+1], shift = k-S+1.
  - Bits below the segment are discarded (floor truncation, no rounding).
- Stage 2: P = seg_a * seg_b. Width is 2*WIDTH, so the product cannot overflow.
- Stage 3: out_y = P << (shift_a + shift_b). The result always fits in 2*WIDTH bits.
- out_approx = 1 iff the beat's mode is not 00 and either shift is non-zero (mode 00 always gives 0).
- Zero operand in any mode: out_y = 0, out_approx = 0.
- Flow control:
  - The pipeline advances when out_ready || !out_valid.
  - Each internal stage also fills when its downstream stage is empty (bubble collapse).
  - in_ready = stage-1 register empty, or the pipeline advances this cycle. in_ready is combinational from out_ready and the stage valid bits; there is no path from in_valid to in_ready.
- Stall: while out_valid && !out_ready, out_y, out_approx and out_valid hold stable. Up to 3 beats are buffered; then in_ready = 0.
- Ordering: results leave strictly in acceptance order. No beat is dropped or duplicated.
- Full throughput: one result per cycle with in_valid = out_ready = 1 continuously.

Test Plan:
- Exact mode (WIDTH=16, SEG_MAX=8, SEG_MIN=5): a=56783, b=6723, mode 00 -> out_y=381752109, out_approx=0, exactly 3 cycles after acceptance.
- Fixed SEG_MAX: a=0xFFAA, b=0x08FA, mode 01 -> segments 0xFF and 0x8F, shift 8+4 -> out_y=149360640, out_approx=1.
- Dynamic: a=0x0392, b=0x01FB, mode 10 -> p=9, S=5, segments 28 and 31, shift 5+4 -> out_y=444416, out_approx=1. Small operands a=25, b=3, mode 10 -> out_y=75, out_approx=0. Zero operand a=0, b=0xFFFF, mode 01 -> out_y=0, out_approx=0.
- Back-pressure: stream 5 mixed-mode beats with out_ready=0 -> in_ready drops after 3 acceptances and out_y is held stable. Then set out_ready=1 -> all 5 results appear in order, matching a reference model, with no loss or duplication.
- Throughput: 100 random beats with in_valid=out_ready=1 -> one result per cycle after 3-cycle fill, all matching the model.
- Reset mid-operation: assert rst for 1 cycle with 2 beats in flight -> next cycle out_valid=0 and out_y=0. No stale results ever emerge, and the first post-reset beat returns with 3-cycle latency.
